draw_game_objects: RTL and testbench
====================================

# draw_game_objects

Frame-synchronous renderer for the ball and both paddles; the parametrised successor of the fixed ball/pad overlay. It sits in the `vga_intf` chain after the background/field drawer and before the output mux. Object positions are sampled once per frame at the start of vertical blanking, so objects never tear mid-frame. Per-object enables, a scalable ball sprite, configurable geometry and colours, and per-frame ball/paddle pixel-overlap flags are provided.

## Interface
Parameters:
- `PAD_W`, 15, paddle width in pixels
- `PAD_H`, 145, paddle height in pixels
- `X_PAD_LEFT`, 30, left paddle left edge
- `X_PAD_RIGHT`, 979, right paddle left edge
- `BALL_SCALE`, 1, ball pixel replication; legal values are 1, 2 and 4
- `BALL_RGB`, 12'hFFF, ball colour
- `PAD_RGB`, 12'hFFF, paddle colour

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `ball_x`, `ball_y`  in  11 each  requested ball top-left corner
- `pad_left_y`, `pad_right_y`  in  11 each  requested paddle top edges
- `obj_en`  in  3  enables: [0] ball, [1] left paddle, [2] right paddle
- `game_field_in`  `vga_intf.in`  —  upstream timing and rgb
- `game_field_out`  `vga_intf.out`  —  downstream timing and rgb
- `frame_tick`  out  1  one-cycle pulse at each vblnk rising edge
- `hit_left`, `hit_right`  out  1 each  ball overlapped the paddle in the previous frame

## Operation
- **Position latch**
  - Registered `vblnk_d`; `vb_rise = in.vblnk & ~vblnk_d`.
  - On `vb_rise`, `ball_x/ball_y/pad_left_y/pad_right_y/obj_en` are copied to shadow registers. Only the shadow values are used for drawing.
- **Ball extent**
  - Extent is `BALL_PX = 16*BALL_SCALE`; the box is inclusive `[x, x+BALL_PX-1]`.
  - Compute bounds in 12 bits so they cannot wrap. A box extending past 1023/767 is clipped naturally.
  - Sprite row = `(vcount - y) >> log2(BALL_SCALE)`; column likewise. Use the full 11-bit subtraction, then the low 4 bits. `ball_on = en[0] & in_box & rom_bit`.
- **Paddles**: `padL_on = en[1] & hcount∈[X_PAD_LEFT, X_PAD_LEFT+PAD_W-1] & vcount∈[yL, yL+PAD_H-1]`. `padR_on` is the same with `X_PAD_RIGHT`/`yR`/`en[2]`.
- **Colour priority**: blank (`hblnk|vblnk`) gives 0; otherwise ball gives `BALL_RGB`; otherwise any paddle gives `PAD_RGB`; otherwise `in.rgb`.
- **Collision accumulation**
  - On a non-blank pixel: `accL |= ball_on & padL_on`, and `accR` likewise.
  - On `vb_rise`: `hit_left <= accL`, `hit_right <= accR`, and both accumulators are cleared in the same cycle. The clear wins over a same-cycle set, which is impossible anyway because pixels are blank there.
  - Hits hold until the next `vb_rise`.
- **Reset values**
  - Shadow ball = `((HOR_PIXELS-16)/2, (VER_PIXELS-16)/2)`; paddles y = 312; `obj_en` shadow = 3'b111.
  - Accumulators, `hit_*`, `frame_tick`, `out.rgb` and all delayed timing signals are 0.

## Timing
- Two-stage pipeline:
  - Stage 1 registers `ball_on`, `padL_on`, `padR_on`, blank and `in.rgb`.
  - Stage 2 registers `out.rgb`.
- `out.hcount/vcount/hsync/vsync/hblnk/vblnk` are `in` delayed by exactly 2 cycles, so they stay aligned with rgb.
- `frame_tick`, `hit_*` and the shadow registers update on the clock edge where `vb_rise` is true. Shadows are visible to the first pixel of the next frame.
- Input position changes mid-frame have no effect until the next `vb_rise`.
- `rst` asserted mid-frame returns to reset values at the next edge. After release, the first `vb_rise` resumes normal latching, and the pipeline refills within 2 cycles.

## Structure
- `game_pkg`: `BALL_ROM_N = 16`, the 16×16 circle bitmap constant, reset positions and default colours. Timing constants come from `vga_pkg`.
- Sub-module `ball_sprite_rom`: combinational; a 4-bit row address returns a 16-bit row.
- Reuse the existing `delay` for timing signals: WIDTH 22 for the counts, 4 for the control signals, with `CLK_DEL` 2.

## Test plan
- **Reset alignment**: hold `rst` for 5 cycles, then release.
  - All outputs are 0 during reset.
  - `out.hcount` equals `in.hcount` delayed by 2 cycles from then on.
- **Mid-frame latch**: draw a ball at (504, 376) and change `ball_x` to 100 mid-frame.
  - The current frame still draws at 504.
  - The next frame draws at 100; pixel (100+7, y+8) = `BALL_RGB`, and corner (100, y) shows background.
- **Scale and clipping**: `BALL_SCALE = 2`, ball at (1016, 760).
  - The box is 32 px, and clipping produces no wrap pixels at hcount 0–23.
  - Sprite rows repeat in pairs.
- **Priority and enables**: place the ball over the left paddle (`ball_x = 30`, `pad_left_y = ball_y`).
  - Overlap pixels = `BALL_RGB`.
  - With `obj_en = 3'b110`, those pixels = `PAD_RGB`, and `hit_left` stays 0.
- **Collision flags**:
  - With an overlap in frame N, `hit_left = 1` from `vb_rise` N until `vb_rise` N+1.
  - With no overlap in frame N+1, it drops to 0.
  - `frame_tick` is exactly 1 cycle wide per frame.
- **Blanking**: feed `in.rgb = 12'hABC` with the ball positioned across `hblnk`; the output is 0 during blank.

Source files
------------

// File: rtl/game_pkg.sv
// Game-object constants: ball bitmap, reset positions and default colours.
package game_pkg;
  import vga_pkg::*;

  localparam int BALL_ROM_N = 16;

  // Row 0 is the top of the ball; bit 15 of a row is its leftmost pixel.
  localparam logic [0:15][15:0] BALL_BITMAP = {
    16'h07E0, 16'h1FF8, 16'h3FFC, 16'h7FFE,
    16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE,
    16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h07E0
  };

  localparam logic [10:0] BALL_X_RST  = 11'((HOR_PIXELS - BALL_ROM_N) / 2);
  localparam logic [10:0] BALL_Y_RST  = 11'((VER_PIXELS - BALL_ROM_N) / 2);
  localparam logic [10:0] PAD_Y_RST   = 11'd312;
  localparam logic [2:0]  OBJ_EN_RST  = 3'b111;
  localparam logic [11:0] BALL_RGB_DEF = 12'hFFF;
  localparam logic [11:0] PAD_RGB_DEF  = 12'hFFF;
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 1024x768 display chain.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/vga_intf.sv
// VGA timing and colour bundle passed between drawing stages.
interface vga_intf;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/ball_sprite_rom.sv
// Combinational 16x16 ball bitmap lookup, one row per address.
module ball_sprite_rom
  import game_pkg::*;
(
  input  logic [3:0]  addr,
  output logic [15:0] data
);
  assign data = BALL_BITMAP[addr];
endmodule

// File: rtl/delay.sv
// Fixed-latency shift register used to keep timing signals aligned with rgb.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe_r [CLK_DEL];

  // Shift stage chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign dout = pipe_r[CLK_DEL-1];
endmodule

// File: rtl/draw_game_objects.sv
// Draws ball and paddles over the field using frame-latched positions and
// reports per-frame ball/paddle overlap.
module draw_game_objects
  import game_pkg::*;
#(
  parameter int          PAD_W       = 15,
  parameter int          PAD_H       = 145,
  parameter int          X_PAD_LEFT  = 30,
  parameter int          X_PAD_RIGHT = 979,
  parameter int          BALL_SCALE  = 1,
  parameter logic [11:0] BALL_RGB    = BALL_RGB_DEF,
  parameter logic [11:0] PAD_RGB     = PAD_RGB_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [10:0] pad_left_y,
  input  logic [10:0] pad_right_y,
  input  logic [2:0]  obj_en,
  vga_intf.in         game_field_in,
  vga_intf.out        game_field_out,
  output logic        frame_tick,
  output logic        hit_left,
  output logic        hit_right
);
  localparam int BALL_PX = BALL_ROM_N * BALL_SCALE;
  localparam int SHIFT   = (BALL_SCALE == 4) ? 2 : ((BALL_SCALE == 2) ? 1 : 0);

  logic        vblnk_d_r, vb_rise_s, blank_s;
  logic [10:0] ball_x_r, ball_y_r, pad_l_y_r, pad_r_y_r;
  logic [2:0]  en_r;
  logic [11:0] hc_s, vc_s, ball_x_hi_s, ball_y_hi_s;
  logic [10:0] dx_s, dy_s;
  logic [3:0]  row_s, col_s;
  logic [15:0] rom_row_s;
  logic        in_box_s, ball_on_s, pad_l_on_s, pad_r_on_s;
  logic        ball_on_r, pad_l_on_r, pad_r_on_r, blank_r;
  logic [11:0] rgb_s1_r, rgb_r;
  logic        acc_l_r, acc_r_r, frame_tick_r, hit_left_r, hit_right_r;

  assign vb_rise_s = game_field_in.vblnk & ~vblnk_d_r;
  assign blank_s   = game_field_in.hblnk | game_field_in.vblnk;

  // Frame-boundary detect and shadow latch of requested positions
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d_r <= 1'b0;
      ball_x_r  <= BALL_X_RST;
      ball_y_r  <= BALL_Y_RST;
      pad_l_y_r <= PAD_Y_RST;
      pad_r_y_r <= PAD_Y_RST;
      en_r      <= OBJ_EN_RST;
    end else begin
      vblnk_d_r <= game_field_in.vblnk;
      if (vb_rise_s) begin
        ball_x_r  <= ball_x;
        ball_y_r  <= ball_y;
        pad_l_y_r <= pad_left_y;
        pad_r_y_r <= pad_right_y;
        en_r      <= obj_en;
      end
    end
  end

  // Twelve-bit bounds so boxes near the screen edge clip instead of wrapping
  always_comb begin
    hc_s        = {1'b0, game_field_in.hcount};
    vc_s        = {1'b0, game_field_in.vcount};
    ball_x_hi_s = {1'b0, ball_x_r} + 12'(BALL_PX - 1);
    ball_y_hi_s = {1'b0, ball_y_r} + 12'(BALL_PX - 1);
    in_box_s    = (hc_s >= {1'b0, ball_x_r}) && (hc_s <= ball_x_hi_s) &&
                  (vc_s >= {1'b0, ball_y_r}) && (vc_s <= ball_y_hi_s);
    dx_s        = game_field_in.hcount - ball_x_r;
    dy_s        = game_field_in.vcount - ball_y_r;
    col_s       = 4'(dx_s >> SHIFT);
    row_s       = 4'(dy_s >> SHIFT);
    ball_on_s   = en_r[0] & in_box_s & rom_row_s[4'd15 - col_s];
    pad_l_on_s  = en_r[1] &
                  (hc_s >= 12'(X_PAD_LEFT)) && (hc_s <= 12'(X_PAD_LEFT + PAD_W - 1)) &&
                  (vc_s >= {1'b0, pad_l_y_r}) && (vc_s <= {1'b0, pad_l_y_r} + 12'(PAD_H - 1));
    pad_r_on_s  = en_r[2] &
                  (hc_s >= 12'(X_PAD_RIGHT)) && (hc_s <= 12'(X_PAD_RIGHT + PAD_W - 1)) &&
                  (vc_s >= {1'b0, pad_r_y_r}) && (vc_s <= {1'b0, pad_r_y_r} + 12'(PAD_H - 1));
  end

  ball_sprite_rom u_rom (
    .addr (row_s),
    .data (rom_row_s)
  );

  // Stage 1 object hits and stage 2 colour priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ball_on_r  <= 1'b0;
      pad_l_on_r <= 1'b0;
      pad_r_on_r <= 1'b0;
      blank_r    <= 1'b0;
      rgb_s1_r   <= 12'h000;
      rgb_r      <= 12'h000;
    end else begin
      ball_on_r  <= ball_on_s;
      pad_l_on_r <= pad_l_on_s;
      pad_r_on_r <= pad_r_on_s;
      blank_r    <= blank_s;
      rgb_s1_r   <= game_field_in.rgb;
      rgb_r      <= blank_r                   ? 12'h000  :
                    ball_on_r                 ? BALL_RGB :
                    (pad_l_on_r | pad_r_on_r) ? PAD_RGB  : rgb_s1_r;
    end
  end

  // Overlap accumulation; the frame-boundary clear takes precedence
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l_r      <= 1'b0;
      acc_r_r      <= 1'b0;
      hit_left_r   <= 1'b0;
      hit_right_r  <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= vb_rise_s;
      if (vb_rise_s) begin
        hit_left_r  <= acc_l_r;
        hit_right_r <= acc_r_r;
        acc_l_r     <= 1'b0;
        acc_r_r     <= 1'b0;
      end else if (!blank_s) begin
        acc_l_r <= acc_l_r | (ball_on_s & pad_l_on_s);
        acc_r_r <= acc_r_r | (ball_on_s & pad_r_on_s);
      end
    end
  end

  logic [21:0] cnt_d_s;
  logic [3:0]  ctl_d_s;

  delay #(.WIDTH(22), .CLK_DEL(2)) u_cnt_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({game_field_in.hcount, game_field_in.vcount}),
    .dout (cnt_d_s)
  );

  delay #(.WIDTH(4), .CLK_DEL(2)) u_ctl_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({game_field_in.hsync, game_field_in.vsync, game_field_in.hblnk, game_field_in.vblnk}),
    .dout (ctl_d_s)
  );

  assign game_field_out.hcount = cnt_d_s[21:11];
  assign game_field_out.vcount = cnt_d_s[10:0];
  assign game_field_out.hsync  = ctl_d_s[3];
  assign game_field_out.vsync  = ctl_d_s[2];
  assign game_field_out.hblnk  = ctl_d_s[1];
  assign game_field_out.vblnk  = ctl_d_s[0];
  assign game_field_out.rgb    = rgb_r;
  assign frame_tick            = frame_tick_r;
  assign hit_left              = hit_left_r;
  assign hit_right             = hit_right_r;
endmodule

// File: tb/tb_draw_game_objects.sv
// Directed bench for draw_game_objects: one scale-1 and one scale-2 instance
// share the same upstream stream; expected colours are hand-derived.
module tb_draw_game_objects;
  localparam logic [11:0] BALL_C = 12'hF00;
  localparam logic [11:0] PAD_C  = 12'h0F0;
  localparam logic [11:0] BG     = 12'h123;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ball_x, ball_y, pad_left_y, pad_right_y;
  logic [2:0]  obj_en;
  logic        frame_tick, hit_left, hit_right;
  logic        frame_tick2, hit_left2, hit_right2;
  int          checks = 0;
  int          errors = 0;

  vga_intf fi ();
  vga_intf fo1 ();
  vga_intf fo2 ();

  always #5 clk = ~clk;

  draw_game_objects #(.BALL_RGB(BALL_C), .PAD_RGB(PAD_C)) dut (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y),
    .pad_left_y(pad_left_y), .pad_right_y(pad_right_y), .obj_en(obj_en),
    .game_field_in(fi), .game_field_out(fo1),
    .frame_tick(frame_tick), .hit_left(hit_left), .hit_right(hit_right)
  );

  draw_game_objects #(.BALL_SCALE(2), .BALL_RGB(BALL_C), .PAD_RGB(PAD_C)) dut2 (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y),
    .pad_left_y(pad_left_y), .pad_right_y(pad_right_y), .obj_en(obj_en),
    .game_field_in(fi), .game_field_out(fo2),
    .frame_tick(frame_tick2), .hit_left(hit_left2), .hit_right(hit_right2)
  );

  // Hold one pixel for two clocks and return both instances' colour for it
  task automatic pixel(input logic [10:0] h, input logic [10:0] v, input logic [11:0] c,
                       input logic hb, output logic [11:0] o1, output logic [11:0] o2);
    fi.hcount = h; fi.vcount = v; fi.rgb = c; fi.hblnk = hb; fi.vblnk = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    o1 = fo1.rgb;
    o2 = fo2.rgb;
  endtask

  task automatic vblank();
    fi.hblnk = 1'b0; fi.vblnk = 1'b1;
    @(posedge clk); @(posedge clk);
    fi.vblnk = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fi.hcount = 11'd123; fi.vcount = 11'd45; fi.rgb = 12'hABC;
    fi.hblnk = 1'b0; fi.vblnk = 1'b0; fi.hsync = 1'b0; fi.vsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      fi.vblnk = i[0];
      checks++;
      if (fo1.rgb !== 12'h000 || fo1.hcount !== 11'd0 || fo1.vblnk !== 1'b0 ||
          frame_tick !== 1'b0 || hit_left !== 1'b0 || hit_right !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: rgb=%h hcount=%0d vblnk=%b tick=%b hitL=%b hitR=%b, want all 0",
                 fo1.rgb, fo1.hcount, fo1.vblnk, frame_tick, hit_left, hit_right);
      end
    end
    fi.vblnk = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      fi.hcount = 11'(200 + k);
      @(posedge clk); #1;
      if (k >= 1) begin
        checks++;
        if (fo1.hcount !== 11'(200 + k - 1)) begin
          errors++;
          $display("FAIL reset_hcount_align: got %0d want %0d", fo1.hcount, 200 + k - 1);
        end
      end
    end
  endtask

  task automatic test_midframe_latch();
    logic [11:0] o1, o2;
    ball_x = 11'd504; ball_y = 11'd376; pad_left_y = 11'd312; pad_right_y = 11'd312;
    obj_en = 3'b111;
    vblank();
    pixel(11'd511, 11'd384, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BALL_C) begin errors++; $display("FAIL latch_old_center: got %h want %h", o1, BALL_C); end
    ball_x = 11'd100;
    pixel(11'd511, 11'd384, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BALL_C) begin errors++; $display("FAIL latch_midframe_hold: got %h want %h", o1, BALL_C); end
    pixel(11'd107, 11'd384, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BG) begin errors++; $display("FAIL latch_not_yet_new: got %h want %h", o1, BG); end
    vblank();
    pixel(11'd107, 11'd384, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BALL_C) begin errors++; $display("FAIL latch_new_center: got %h want %h", o1, BALL_C); end
    pixel(11'd100, 11'd376, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BG) begin errors++; $display("FAIL latch_new_corner: got %h want %h", o1, BG); end
    pixel(11'd511, 11'd384, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BG) begin errors++; $display("FAIL latch_old_gone: got %h want %h", o1, BG); end
  endtask

  task automatic test_priority_collision();
    logic [11:0] o1, o2;
    ball_x = 11'd30; ball_y = 11'd300; pad_left_y = 11'd300; obj_en = 3'b111;
    vblank();
    pixel(11'd37, 11'd308, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BALL_C) begin errors++; $display("FAIL prio_ball_over_pad: got %h want %h", o1, BALL_C); end
    pixel(11'd30, 11'd300, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== PAD_C) begin errors++; $display("FAIL prio_pad_corner: got %h want %h", o1, PAD_C); end
    obj_en = 3'b110;
    fi.vblnk = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (frame_tick !== 1'b1 || hit_left !== 1'b1 || hit_right !== 1'b0) begin
      errors++;
      $display("FAIL hit_set_on_vb: tick=%b hitL=%b hitR=%b want 1 1 0", frame_tick, hit_left, hit_right);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_tick !== 1'b0 || hit_left !== 1'b1) begin
      errors++;
      $display("FAIL tick_width: tick=%b hitL=%b want 0 1", frame_tick, hit_left);
    end
    fi.vblnk = 1'b0;
    @(posedge clk); #1;
    pixel(11'd37, 11'd308, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== PAD_C || hit_left !== 1'b1) begin
      errors++;
      $display("FAIL ball_disabled: rgb=%h hitL=%b want %h 1", o1, hit_left, PAD_C);
    end
    vblank();
    checks++;
    if (hit_left !== 1'b0 || hit_right !== 1'b0) begin
      errors++;
      $display("FAIL hit_clear_next_frame: hitL=%b hitR=%b want 0 0", hit_left, hit_right);
    end
  endtask

  task automatic test_scale_clip();
    logic [11:0] o1, o2;
    ball_x = 11'd1016; ball_y = 11'd760; pad_left_y = 11'd312; obj_en = 3'b111;
    vblank();
    pixel(11'd1023, 11'd760, BG, 1'b0, o1, o2);
    checks++;
    if (o2 !== BG || o1 !== BALL_C) begin
      errors++;
      $display("FAIL scale_row0: s2=%h s1=%h want %h %h", o2, o1, BG, BALL_C);
    end
    pixel(11'd1023, 11'd761, BG, 1'b0, o1, o2);
    checks++;
    if (o2 !== BG) begin errors++; $display("FAIL scale_row0_pair: got %h want %h", o2, BG); end
    pixel(11'd1023, 11'd762, BG, 1'b0, o1, o2);
    checks++;
    if (o2 !== BALL_C) begin errors++; $display("FAIL scale_row1: got %h want %h", o2, BALL_C); end
    pixel(11'd1023, 11'd763, BG, 1'b0, o1, o2);
    checks++;
    if (o2 !== BALL_C) begin errors++; $display("FAIL scale_row1_pair: got %h want %h", o2, BALL_C); end
    pixel(11'd10, 11'd762, BG, 1'b0, o1, o2);
    checks++;
    if (o2 !== BG) begin errors++; $display("FAIL clip_nowrap_10: got %h want %h", o2, BG); end
    pixel(11'd23, 11'd763, BG, 1'b0, o1, o2);
    checks++;
    if (o2 !== BG) begin errors++; $display("FAIL clip_nowrap_23: got %h want %h", o2, BG); end
  endtask

  task automatic test_midframe_reset();
    logic [11:0] o1, o2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pixel(11'd511, 11'd384, BG, 1'b0, o1, o2);
    checks++;
    if (o1 !== BALL_C || hit_left !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset_shadow: rgb=%h hitL=%b want %h 0", o1, hit_left, BALL_C);
    end
  endtask

  task automatic test_blanking();
    logic [11:0] o1, o2;
    ball_x = 11'd504; ball_y = 11'd376; obj_en = 3'b111;
    vblank();
    pixel(11'd511, 11'd384, 12'hABC, 1'b1, o1, o2);
    checks++;
    if (o1 !== 12'h000) begin errors++; $display("FAIL blank_ball: got %h want 000", o1); end
    pixel(11'd511, 11'd384, 12'hABC, 1'b0, o1, o2);
    checks++;
    if (o1 !== BALL_C) begin errors++; $display("FAIL unblank_ball: got %h want %h", o1, BALL_C); end
    pixel(11'd400, 11'd384, 12'hABC, 1'b0, o1, o2);
    checks++;
    if (o1 !== 12'hABC) begin errors++; $display("FAIL passthrough_bg: got %h want ABC", o1); end
    pixel(11'd400, 11'd384, 12'hABC, 1'b1, o1, o2);
    checks++;
    if (o1 !== 12'h000) begin errors++; $display("FAIL blank_bg: got %h want 000", o1); end
  endtask

  initial begin
    ball_x = 11'd0; ball_y = 11'd0; pad_left_y = 11'd0; pad_right_y = 11'd0;
    obj_en = 3'b000;
    test_reset();
    test_midframe_latch();
    test_priority_collision();
    test_scale_clip();
    test_midframe_reset();
    test_blanking();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
